pipe_bus_arbiter: RTL
=====================

Name: pipe_bus_arbiter

Overview:
- Owns the shared memory bus in front of pipeline stage 0.
- Instruction fetch is the default owner. The block steals bus cycles for pipeline data accesses (mem) and for external DMA bursts.
- It generates the stage-0 BusRequest/FetchSuppress controls so that stolen cycles inject NOPs instead of garbage opcodes.
- Moore FSM with registered outputs; includes starvation and timeout protection.

Parameters:
- MAX_MEM_STREAK, 4: consecutive mem grants allowed while dma_req is pending before DMA is forced to win.
- MAX_DMA_CYCLES, 64: maximum DMA_ACTIVE cycles per grant before forced release.
- CNT_W, 16: width of the stolen-cycle statistics counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_req  in  1  pipeline data-access request; held high until mem_ack is seen, then dropped.
- mem_ack  out  1  bus granted to data access for this cycle.
- dma_req  in  1  external DMA request; held high for the whole burst.
- dma_gnt  out  1  DMA owns the bus.
- dma_timeout  out  1  one-cycle pulse when a DMA grant was force-released.
- BusRequest  out  1  to stage 0; 1 = bus is not fetching.
- FetchSuppress  out  1  to stage 0.
- arb_state  out  3  current FSM state encoding, for debug.
- stolen_cycles  out  CNT_W  count of non-FETCH cycles (see Optional Feature).

Behaviour:
- Stage-0 control encoding {FetchSuppress,BusRequest}:
  - 00 = pass fetched byte
  - 01 = inject NOP (0x00)
  - 11 = replay latched byte (never driven by this block)
  - 10 = output zero
- States and encodings: FETCH=0, MEM=1, DMA_GRANT=2, DMA_ACTIVE=3, RESUME=4.
- All outputs decode from the state register only. There is no combinational input-to-output path.
- Reset (rst_n=0 at a clk edge):
  - state=FETCH; mem_streak=0; dma_cnt=0; stolen_cycles=0.
  - Outputs: mem_ack=0, dma_gnt=0, dma_timeout=0, BusRequest=0, FetchSuppress=0.
  - Reset mid-burst drops dma_gnt on that same edge.
- FETCH (controls 00): arbitration happens only here.
  - If dma_req and (mem_streak==MAX_MEM_STREAK or !mem_req) -> DMA_GRANT.
  - Else if mem_req -> MEM.
  - Else stay in FETCH.
  - Simultaneous mem_req and dma_req with mem_streak<MAX_MEM_STREAK: mem wins.
- MEM (controls 01, mem_ack=1): exactly one cycle, always -> FETCH.
  - Back-to-back data accesses are therefore separated by at least one fetch cycle, which guarantees instruction forward progress.
  - mem_streak increments (saturating at MAX_MEM_STREAK) on entry to MEM if dma_req=1.
  - mem_streak clears whenever dma_req=0 in FETCH, or on entry to DMA_GRANT.
- DMA_GRANT (controls 01, dma_gnt=0): one turnaround cycle, always -> DMA_ACTIVE. dma_cnt cleared.
- DMA_ACTIVE (controls 01, dma_gnt=1): dma_cnt increments each cycle.
  - If dma_req=0 -> RESUME.
  - Else if dma_cnt==MAX_DMA_CYCLES-1 -> RESUME with timeout flag set.
  - If dma_req drops on the same cycle as the limit is reached, this is a normal release: no timeout.
- RESUME (controls 10, dma_gnt=0): one turnaround cycle, always -> FETCH.
  - dma_timeout=1 in this cycle only if the flag is set; the flag clears on exit.
- DMA asserting dma_req again immediately after a timeout is re-arbitrated normally from FETCH. At least one FETCH cycle always occurs between grants.
- mem_req arriving during a DMA grant waits. It is served from FETCH after RESUME; mem has priority there unless mem_streak is saturated.
- dma_req dropping in DMA_GRANT still enters DMA_ACTIVE for one cycle, then exits to RESUME.

Optional Feature:
- Macro: PIPE_ARB_STATS_EN.
- Defined: stolen_cycles increments by 1 every cycle the state is not FETCH. It saturates at all-ones (no wrap) and clears only on reset.
- Not defined: stolen_cycles is tied to 0 and no counter flops are built.

Test Plan:
- Reset then idle 10 cycles -> BusRequest=0, FetchSuppress=0, arb_state=0, all grants 0 throughout.
- Single mem_req pulse, held until ack -> mem_ack high for exactly 1 cycle, one cycle after the request is sampled; BusRequest=1 that cycle only; returns to FETCH.
- mem_req and dma_req held high together, MAX_MEM_STREAK=4 -> sequence MEM,FETCH ×4, then DMA_GRANT; dma_gnt asserts 2 cycles after the 4th post-MEM FETCH cycle.
- dma_req held 10 cycles -> DMA_GRANT 1 cycle, dma_gnt=1 for 10 cycles (dma_req drop seen on the last), RESUME with controls 10 for 1 cycle, dma_timeout never asserted.
- dma_req held forever, MAX_DMA_CYCLES=64 -> dma_gnt high for exactly 64 cycles, dma_timeout pulses 1 cycle in RESUME, then at least 1 FETCH cycle before the next DMA_GRANT.
- rst_n low mid-DMA_ACTIVE -> next edge: dma_gnt=0, state FETCH, stolen_cycles=0; with PIPE_ARB_STATS_EN, 1 MEM access plus a 10-cycle DMA burst gives stolen_cycles=13.

Source files
------------

// File: rtl/pipe_bus_arbiter.sv
// Shared memory bus arbiter ahead of pipeline stage 0: fetch by default, with cycles stolen for data and DMA.
// Optional stolen-cycle statistics counter built only when PIPE_ARB_STATS_EN is defined.
module pipe_bus_arbiter #(
   parameter int unsigned MAX_MEM_STREAK = 4,
   parameter int unsigned MAX_DMA_CYCLES = 64,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_req,
   output logic             mem_ack,
   input  logic             dma_req,
   output logic             dma_gnt,
   output logic             dma_timeout,
   output logic             BusRequest,
   output logic             FetchSuppress,
   output logic [2:0]       arb_state,
   output logic [CNT_W-1:0] stolen_cycles
);

   localparam int unsigned STREAK_W = $clog2(MAX_MEM_STREAK + 1);
   localparam int unsigned DMA_W    = $clog2(MAX_DMA_CYCLES + 1);

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);
   localparam logic [DMA_W-1:0]    DMA_LAST   = DMA_W'(MAX_DMA_CYCLES - 1);

   typedef enum logic [2:0] {
      FETCH      = 3'd0,
      MEM        = 3'd1,
      DMA_GRANT  = 3'd2,
      DMA_ACTIVE = 3'd3,
      RESUME     = 3'd4
   } arbState_t;

   arbState_t            state;
   arbState_t            nextState;
   logic [STREAK_W-1:0]  memStreak;
   logic [STREAK_W-1:0]  memStreakNext;
   logic [DMA_W-1:0]     dmaCnt;
   logic [DMA_W-1:0]     dmaCntNext;
   logic                 timeoutFlag;
   logic                 timeoutFlagNext;
   logic                 memAckNext;
   logic                 dmaGntNext;
   logic                 dmaTimeoutNext;
   logic                 busRequestNext;
   logic                 fetchSuppressNext;

   // State register, bookkeeping counters and output flops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= FETCH;
         memStreak     <= '0;
         dmaCnt        <= '0;
         timeoutFlag   <= 1'b0;
         mem_ack       <= 1'b0;
         dma_gnt       <= 1'b0;
         dma_timeout   <= 1'b0;
         BusRequest    <= 1'b0;
         FetchSuppress <= 1'b0;
      end else begin
         state         <= nextState;
         memStreak     <= memStreakNext;
         dmaCnt        <= dmaCntNext;
         timeoutFlag   <= timeoutFlagNext;
         mem_ack       <= memAckNext;
         dma_gnt       <= dmaGntNext;
         dma_timeout   <= dmaTimeoutNext;
         BusRequest    <= busRequestNext;
         FetchSuppress <= fetchSuppressNext;
      end
   end

   assign arb_state = state;

   // Next-state logic; outputs are decoded from the next state so the flops line up with the state register.
   always_comb begin
      nextState       = state;
      memStreakNext   = memStreak;
      dmaCntNext      = dmaCnt;
      timeoutFlagNext = timeoutFlag;

      unique case (state)
         FETCH: begin
            if (!dma_req) begin
               memStreakNext = '0;
            end
            if (dma_req && ((memStreak == STREAK_MAX) || !mem_req)) begin
               nextState     = DMA_GRANT;
               memStreakNext = '0;
            end else if (mem_req) begin
               nextState = MEM;
               if (dma_req && (memStreak != STREAK_MAX)) begin
                  memStreakNext = memStreak + STREAK_W'(1);
               end
            end
         end
         MEM: begin
            nextState = FETCH;
         end
         DMA_GRANT: begin
            nextState  = DMA_ACTIVE;
            dmaCntNext = '0;
         end
         DMA_ACTIVE: begin
            dmaCntNext = dmaCnt + DMA_W'(1);
            // A request dropping on the limit cycle is a normal release, so check it first.
            if (!dma_req) begin
               nextState = RESUME;
            end else if (dmaCnt == DMA_LAST) begin
               nextState       = RESUME;
               timeoutFlagNext = 1'b1;
            end
         end
         RESUME: begin
            nextState       = FETCH;
            timeoutFlagNext = 1'b0;
         end
         default: begin
            nextState       = FETCH;
            timeoutFlagNext = 1'b0;
         end
      endcase

      memAckNext        = (nextState == MEM);
      dmaGntNext        = (nextState == DMA_ACTIVE);
      busRequestNext    = (nextState == MEM) || (nextState == DMA_GRANT) || (nextState == DMA_ACTIVE);
      fetchSuppressNext = (nextState == RESUME);
      dmaTimeoutNext    = (nextState == RESUME) && timeoutFlagNext;
   end

`ifdef PIPE_ARB_STATS_EN
   // Saturating count of cycles in which the bus was not fetching.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stolen_cycles <= '0;
      end else if ((state != FETCH) && (stolen_cycles != '1)) begin
         stolen_cycles <= stolen_cycles + CNT_W'(1);
      end
   end
`else
   assign stolen_cycles = '0;
`endif

endmodule
